// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side front end for the 8-bit i8080 ALU.
//
// A decoded opcode and its operands are accepted on a valid/ready port. The
// opcode is translated into the ALU's 5-bit control code. Registered operands
// and the flags input drive an external combinational ALU. Its result is
// captured and returned on a second valid/ready port. DAD is run as two ALU
// passes: the low byte first, then the high byte. The carry between the two
// passes goes through a temporary flag register, so the architectural flags
// change only once.
//
// Handshake rule (both ports): a transfer happens on the rising clock edge
// where valid && ready are both high. Valid, once raised, stays high and the
// payload stays constant until that edge. Ready never depends on valid.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command port; ready only in IDLE with flags_load low
//   cmd_opcode, cmd_a, cmd_b   8080 opcode, accumulator, source/immediate
//   cmd_hl, cmd_rp             16-bit operands for DAD
//   flags_load, flags_wdata    direct flag-register load (POP PSW), IDLE only
//   alu_op_a/b, alu_control    registered operands and control to the ALU
//   alu_flags_in               flags presented to the ALU
//   alu_out, alu_flags_out     combinational ALU result
//   res_valid / res_ready      result port
//   res_data                   result; upper byte zero unless DAD
//   res_write, res_illegal     destination write enable, unsupported opcode
//   flags                      architectural flags (S7 Z6 A4 P2 C0, bit 1 = 1)
//   dbg_state                  current FSM state, for observation
module alu_sequencer #(
  parameter int              XLEN      = 8,
  parameter logic [XLEN-1:0] FLAGS_RST = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_opcode,
  input  logic [XLEN-1:0]   cmd_a,
  input  logic [XLEN-1:0]   cmd_b,
  input  logic [2*XLEN-1:0] cmd_hl,
  input  logic [2*XLEN-1:0] cmd_rp,
  input  logic              flags_load,
  input  logic [XLEN-1:0]   flags_wdata,
  output logic [XLEN-1:0]   alu_op_a,
  output logic [XLEN-1:0]   alu_op_b,
  output logic [4:0]        alu_control,
  output logic [XLEN-1:0]   alu_flags_in,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   alu_flags_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*XLEN-1:0] res_data,
  output logic              res_write,
  output logic              res_illegal,
  output logic [XLEN-1:0]   flags,
  output logic [1:0]        dbg_state
);

  // Bit 1 of the 8080 flag byte always reads as one.
  localparam logic [XLEN-1:0] FLAG_B1 = XLEN'(2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_EXEC_HI = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state, w_next;
  logic              w_cmd_ready, w_accept;
  logic              w_legal, w_is_dad, w_write;
  logic [4:0]        w_ctl;
  logic [XLEN-1:0]   w_op_a, w_op_b;

  logic [XLEN-1:0]   r_alu_a, r_alu_b;
  logic [4:0]        r_alu_ctl;
  logic [XLEN-1:0]   r_flags, r_flags_tmp;
  logic [XLEN-1:0]   r_hl_hi, r_rp_hi;
  logic              r_is_dad;
  logic [2*XLEN-1:0] r_res_data;
  logic              r_res_write, r_res_illegal;

  // Opcode decode: control = {group, op}.
  always_comb begin
    w_legal  = 1'b1;
    w_is_dad = 1'b0;
    w_write  = 1'b1;
    w_ctl    = 5'b00000;
    w_op_a   = cmd_a;
    w_op_b   = cmd_b;
    if (cmd_opcode[7:6] == 2'b10 ||
        (cmd_opcode[7:6] == 2'b11 && cmd_opcode[2:0] == 3'b110)) begin
      // Register or immediate arithmetic/logic; CMP only updates flags.
      w_ctl   = {2'b00, cmd_opcode[5:3]};
      w_write = (cmd_opcode[5:3] != 3'b111);
    end else if (cmd_opcode[7:6] == 2'b00 && cmd_opcode[3:0] == 4'b1001) begin
      w_is_dad = 1'b1;
      w_ctl    = 5'b11000;
      w_op_a   = cmd_hl[XLEN-1:0];
      w_op_b   = cmd_rp[XLEN-1:0];
    end else if (cmd_opcode[7:6] == 2'b00 && cmd_opcode[2:0] == 3'b100) begin
      w_ctl = 5'b10000;                        // INR
    end else if (cmd_opcode[7:6] == 2'b00 && cmd_opcode[2:0] == 3'b101) begin
      w_ctl = 5'b10001;                        // DCR
    end else if (cmd_opcode[7:6] == 2'b00 && cmd_opcode[2:0] == 3'b111) begin
      // Rotates/DAA/CMA/STC/CMC; STC (110) and CMC (111) touch only carry.
      w_ctl   = {2'b01, cmd_opcode[5:3]};
      w_write = (cmd_opcode[5:4] != 2'b11);
    end else begin
      w_legal = 1'b0;
      w_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = !flags_load;
        w_accept    = cmd_valid && w_cmd_ready;
        if (w_accept) w_next = w_legal ? S_EXEC : S_DONE;
      end
      S_EXEC:    w_next = r_is_dad ? S_EXEC_HI : S_DONE;
      S_EXEC_HI: w_next = S_DONE;
      S_DONE:    if (res_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_ctl     <= 5'b00000;
      r_flags       <= FLAGS_RST;
      r_flags_tmp   <= FLAGS_RST;
      r_hl_hi       <= '0;
      r_rp_hi       <= '0;
      r_is_dad      <= 1'b0;
      r_res_data    <= '0;
      r_res_write   <= 1'b0;
      r_res_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flags_load) begin
            r_flags <= flags_wdata | FLAG_B1;
          end else if (w_accept) begin
            r_alu_a       <= w_op_a;
            r_alu_b       <= w_op_b;
            r_alu_ctl     <= w_ctl;
            r_is_dad      <= w_is_dad;
            r_hl_hi       <= cmd_hl[2*XLEN-1:XLEN];
            r_rp_hi       <= cmd_rp[2*XLEN-1:XLEN];
            r_res_data    <= '0;
            r_res_write   <= w_write;
            r_res_illegal <= !w_legal;
          end
        end
        S_EXEC: begin
          r_res_data <= {{XLEN{1'b0}}, alu_out};
          if (r_is_dad) begin
            // Low-byte carry is parked here; architectural flags stay put
            // until the high byte completes.
            r_flags_tmp <= alu_flags_out;
            r_alu_a     <= r_hl_hi;
            r_alu_b     <= r_rp_hi;
            r_alu_ctl   <= 5'b11001;
          end else begin
            r_flags <= alu_flags_out | FLAG_B1;
          end
        end
        S_EXEC_HI: begin
          r_res_data[2*XLEN-1:XLEN] <= alu_out;
          r_flags                   <= alu_flags_out | FLAG_B1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready    = w_cmd_ready;
  assign alu_op_a     = r_alu_a;
  assign alu_op_b     = r_alu_b;
  assign alu_control  = r_alu_ctl;
  assign alu_flags_in = (r_state == S_EXEC_HI) ? r_flags_tmp : r_flags;
  assign res_valid    = (r_state == S_DONE);
  assign res_data     = r_res_data;
  assign res_write    = r_res_write;
  assign res_illegal  = r_res_illegal;
  assign flags        = r_flags;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. It holds a behavioural i8080 ALU stub that answers
// the DUT's control code. It also holds an opcode-level reference model that
// predicts result, flags, write, illegal and latency directly from the 8080
// meaning of each opcode.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_opcode, cmd_a, cmd_b;
  logic [15:0] cmd_hl, cmd_rp;
  logic        flags_load;
  logic [7:0]  flags_wdata;
  logic [7:0]  alu_op_a, alu_op_b;
  logic [4:0]  alu_control;
  logic [7:0]  alu_flags_in, alu_out, alu_flags_out;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_write, res_illegal;
  logic [7:0]  flags;
  logic [1:0]  dbg_state;
  logic [15:0] stub_t;

  int total = 0;
  int bad   = 0;
  logic [7:0]  m_flags;
  logic [15:0] obs_data;
  logic [7:0]  obs_flags;
  logic        obs_write, obs_illegal;
  int          obs_lat;

  localparam int K_ADD = 0,  K_ADC = 1,  K_SUB = 2,  K_SBB = 3;
  localparam int K_ANA = 4,  K_XRA = 5,  K_ORA = 6,  K_CMP = 7;
  localparam int K_RLC = 8,  K_RRC = 9,  K_RAL = 10, K_RAR = 11;
  localparam int K_DAA = 12, K_CMA = 13, K_STC = 14, K_CMC = 15;
  localparam int K_INR = 16, K_DCR = 17, K_DADL = 18, K_DADH = 19;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_hl(cmd_hl), .cmd_rp(cmd_rp),
    .flags_load(flags_load), .flags_wdata(flags_wdata),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_control(alu_control),
    .alu_flags_in(alu_flags_in), .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_write(res_write), .res_illegal(res_illegal), .flags(flags),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural 8080 ALU ----------------
  function automatic logic [7:0] mkf(input logic [7:0] r, input logic ac, input logic c);
    return {r[7], (r == 8'h00), 1'b0, ac, 1'b0, ~(^r), 1'b1, c};
  endfunction

  function automatic logic [15:0] op8(input int k, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] f);
    logic [8:0] s;
    logic [4:0] h;
    logic [7:0] adj;
    logic       cin, c;
    cin = (k == K_ADC || k == K_SBB || k == K_DADH) ? f[0] : 1'b0;
    case (k)
      K_ADD, K_ADC: begin
        s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        h = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, cin};
        return {s[7:0], mkf(s[7:0], h[4], s[8])};
      end
      K_SUB, K_SBB, K_CMP: begin
        s = {1'b0, a} - {1'b0, b} - {8'h00, cin};
        h = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, cin};
        return {s[7:0], mkf(s[7:0], h[4], s[8])};
      end
      K_ANA: return {a & b, mkf(a & b, a[3] | b[3], 1'b0)};
      K_XRA: return {a ^ b, mkf(a ^ b, 1'b0, 1'b0)};
      K_ORA: return {a | b, mkf(a | b, 1'b0, 1'b0)};
      K_RLC: return {{a[6:0], a[7]}, {f[7:1], a[7]}};
      K_RRC: return {{a[0], a[7:1]}, {f[7:1], a[0]}};
      K_RAL: return {{a[6:0], f[0]}, {f[7:1], a[7]}};
      K_RAR: return {{f[0], a[7:1]}, {f[7:1], a[0]}};
      K_DAA: begin
        adj = 8'h00;
        c   = f[0];
        if (a[3:0] > 4'd9 || f[4]) adj[3:0] = 4'h6;
        if (a > 8'h99 || f[0]) begin
          adj[7:4] = 4'h6;
          c        = 1'b1;
        end
        s = {1'b0, a} + {1'b0, adj};
        h = {1'b0, a[3:0]} + {1'b0, adj[3:0]};
        return {s[7:0], mkf(s[7:0], h[4], c)};
      end
      K_CMA: return {~a, f};
      K_STC: return {a, {f[7:1], 1'b1}};
      K_CMC: return {a, {f[7:1], ~f[0]}};
      K_INR: begin
        s = {1'b0, b} + 9'd1;
        return {s[7:0], mkf(s[7:0], b[3:0] == 4'hF, f[0])};
      end
      K_DCR: begin
        s = {1'b0, b} - 9'd1;
        return {s[7:0], mkf(s[7:0], b[3:0] == 4'h0, f[0])};
      end
      K_DADL, K_DADH: begin
        s = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        return {s[7:0], {f[7:1], s[8]}};
      end
      default: return {8'h00, f};
    endcase
  endfunction

  function automatic int ctl_kind(input logic [4:0] c);
    case (c[4:3])
      2'b00:   return K_ADD + int'(c[2:0]);
      2'b01:   return K_RLC + int'(c[2:0]);
      2'b10:   return (c[2:0] == 3'd0) ? K_INR : (c[2:0] == 3'd1) ? K_DCR : -1;
      default: return (c[2:0] == 3'd0) ? K_DADL : (c[2:0] == 3'd1) ? K_DADH : -1;
    endcase
  endfunction

  assign stub_t        = op8(ctl_kind(alu_control), alu_op_a, alu_op_b, alu_flags_in);
  assign alu_out       = stub_t[15:8];
  assign alu_flags_out = stub_t[7:0];

  // ---------------- opcode-level reference ----------------
  task automatic model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] hl, input logic [15:0] rp, input logic [7:0] f,
                       output logic [15:0] d, output logic [7:0] fo,
                       output logic w, output logic il, output int lat);
    logic [16:0] s;
    logic [15:0] rf;
    d = 16'h0000; fo = f; w = 1'b1; il = 1'b0; lat = 2;
    if (op[7:6] == 2'b00 && op[3:0] == 4'h9) begin
      s   = {1'b0, hl} + {1'b0, rp};
      d   = s[15:0];
      fo  = {f[7:1], s[16]};
      lat = 3;
    end else if (op[7:6] == 2'b10 || (op[7:6] == 2'b11 && op[2:0] == 3'b110)) begin
      rf = op8(K_ADD + int'(op[5:3]), a, b, f);
      d  = {8'h00, rf[15:8]}; fo = rf[7:0];
      w  = (op[5:3] != 3'd7);
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b100) begin
      rf = op8(K_INR, a, b, f); d = {8'h00, rf[15:8]}; fo = rf[7:0];
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b101) begin
      rf = op8(K_DCR, a, b, f); d = {8'h00, rf[15:8]}; fo = rf[7:0];
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b111) begin
      rf = op8(K_RLC + int'(op[5:3]), a, b, f);
      d  = {8'h00, rf[15:8]}; fo = rf[7:0];
      w  = !(op == 8'h37 || op == 8'h3F);
    end else begin
      w = 1'b0; il = 1'b1; lat = 1;
    end
  endtask

  // ---------------- checking and drivers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic flags_ld(input logic [7:0] v);
    @(negedge clk);
    flags_load  = 1'b1;
    flags_wdata = v;
    #1;
    chk("flags_load_blocks_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    flags_load = 1'b0;
    m_flags    = v | 8'h02;
    chk("flags_after_load", 32'(flags), 32'(m_flags));
  endtask

  // Presents a command and returns 1 time unit after the accepting edge.
  task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] hl, input logic [15:0] rp);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_hl = hl; cmd_rp = rp;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Called right after the accepting edge; measures latency in edges,
  // checks the result, holds it for 'hold' cycles, then consumes it.
  task automatic collect(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] hl, input logic [15:0] rp, input int hold);
    logic [15:0] ed;
    logic [7:0]  ef;
    logic        ew, eil;
    int          el, k;
    model(op, a, b, hl, rp, m_flags, ed, ef, ew, eil, el);
    k = 1;
    @(negedge clk);
    while (!res_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(el));
    if (!eil) chk("res_data", 32'(res_data), 32'(ed));
    chk("res_write", 32'(res_write), 32'(ew));
    chk("res_illegal", 32'(res_illegal), 32'(eil));
    chk("flags", 32'(flags), 32'(ef));
    obs_data = res_data; obs_flags = flags; obs_write = res_write;
    obs_illegal = res_illegal; obs_lat = k;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      if (!eil) chk("hold_data", 32'(res_data), 32'(ed));
      chk("hold_write", 32'(res_write), 32'(ew));
      chk("hold_flags", 32'(flags), 32'(ef));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    m_flags = ef;
  endtask

  task automatic run(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] hl, input logic [15:0] rp, input int hold);
    issue(op, a, b, hl, rp);
    collect(op, a, b, hl, rp, hold);
  endtask

  initial begin
    logic [7:0]  r_op, r_a, r_b;
    logic [15:0] r_hl, r_rp;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_a = 8'h00; cmd_b = 8'h00;
    cmd_hl = 16'h0000; cmd_rp = 16'h0000; flags_load = 1'b0; flags_wdata = 8'h00;
    res_ready = 1'b0; m_flags = 8'h02;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'h02);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_write", 32'(res_write), 32'd0);
    chk("rst_res_illegal", 32'(res_illegal), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_alu_op_a", 32'(alu_op_a), 32'd0);
    chk("rst_alu_op_b", 32'(alu_op_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD B
    run(8'h80, 8'h3A, 8'hC6, 16'h0000, 16'h0000, 0);
    chk("add_lat", 32'(obs_lat), 32'd2);
    chk("add_data", 32'(obs_data), 32'h0000);
    chk("add_write", 32'(obs_write), 32'd1);
    chk("add_flags", 32'(obs_flags), 32'h57);

    // DAD B
    flags_ld(8'h02);
    run(8'h09, 8'h00, 8'h00, 16'h80FF, 16'h8001, 0);
    chk("dad_lat", 32'(obs_lat), 32'd3);
    chk("dad_data", 32'(obs_data), 32'h0100);
    chk("dad_flags", 32'(obs_flags), 32'h03);

    // CMP B
    flags_ld(8'h02);
    run(8'hB8, 8'h05, 8'h07, 16'h0000, 16'h0000, 0);
    chk("cmp_data", 32'(obs_data), 32'h00FE);
    chk("cmp_write", 32'(obs_write), 32'd0);
    chk("cmp_flags", 32'(obs_flags), 32'h93);

    // INR A then an unsupported opcode
    flags_ld(8'h03);
    run(8'h3C, 8'h00, 8'hFF, 16'h0000, 16'h0000, 0);
    chk("inr_data", 32'(obs_data), 32'h0000);
    chk("inr_flags", 32'(obs_flags), 32'h57);
    run(8'h00, 8'h12, 8'h34, 16'h0000, 16'h0000, 0);
    chk("ill_illegal", 32'(obs_illegal), 32'd1);
    chk("ill_write", 32'(obs_write), 32'd0);
    chk("ill_flags", 32'(obs_flags), 32'h57);

    // Backpressure with a queued command behind it
    issue(8'h88, 8'h12, 8'h34, 16'h0000, 16'h0000);
    cmd_valid = 1'b1; cmd_opcode = 8'h90; cmd_a = 8'h50; cmd_b = 8'h20;
    collect(8'h88, 8'h12, 8'h34, 16'h0000, 16'h0000, 3);
    chk("queued_ready_after_hs", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("queued_taken", 32'(cmd_ready), 32'd0);
    collect(8'h90, 8'h50, 8'h20, 16'h0000, 16'h0000, 0);

    // flags_load while busy is ignored
    issue(8'hA0, 8'h5C, 8'h3B, 16'h0000, 16'h0000);
    flags_load = 1'b1; flags_wdata = 8'hFF;
    collect(8'hA0, 8'h5C, 8'h3B, 16'h0000, 16'h0000, 2);
    flags_load = 1'b0;

    // Randomized commands against the reference model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) flags_ld(8'($urandom_range(0, 255)));
      r_op = 8'($urandom_range(0, 255));
      r_a  = 8'($urandom_range(0, 255));
      r_b  = 8'($urandom_range(0, 255));
      r_hl = 16'($urandom_range(0, 65535));
      r_rp = 16'($urandom_range(0, 65535));
      run(r_op, r_a, r_b, r_hl, r_rp, $urandom_range(0, 2));
    end

    // Reset during the high-byte pass of DAD
    flags_ld(8'h02);
    issue(8'h19, 8'h00, 8'h00, 16'hFFFF, 16'h0001);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(res_valid), 32'd0);
    chk("rst_mid_flags", 32'(flags), 32'h02);
    chk("rst_mid_data", 32'(res_data), 32'd0);
    chk("rst_mid_alu_control", 32'(alu_control), 32'd0);
    m_flags = 8'h02;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(cmd_ready), 32'd1);
    flags_ld(8'hD5);
    chk("load_d5_flags", 32'(flags), 32'hD7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
